// File: rtl/snn_ff_pkg.sv
// Shared definitions for the spiking-network fabric: default widths and the
// AER transmit handshake state encoding.
package snn_ff;

  localparam int AER_WIDTH_DEF      = 12;
  localparam int DROP_CNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_REQ_HI      = 2'd1,
    ST_WAIT_ACK_LO = 2'd2
  } aer_state_e;

endpackage

// File: rtl/aer_spike_encoder_sync_fifo.sv
// Circular spike buffer. A push into a full buffer is accepted only when a pop
// frees the head slot on the same edge.
module sync_fifo
  import snn_ff::*;
#(
  parameter int WIDTH = AER_WIDTH_DEF,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != DEPTH_C) || pop_ok);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/aer_spike_encoder.sv
// Buffers neuron spikes and emits them as AER events over a 4-phase REQ/ACK
// link whose ACK is asynchronous to CLK.
module aer_spike_encoder
  import snn_ff::*;
#(
  parameter int AER_WIDTH      = AER_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 16,
  parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      spike_in,
  input  logic [AER_WIDTH-1:0]      spike_addr,
  input  logic                      time_ref_event,
  output logic [AER_WIDTH-1:0]      AEROUT_ADDR,
  output logic                      AEROUT_REQ,
  input  logic                      AEROUT_ACK,
  output logic                      busy,
  output logic                      fifo_full,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  aer_state_e                state_q, state_d;
  logic                      ack_meta_q, ack_s_q;
  logic                      req_q, req_d;
  logic [AER_WIDTH-1:0]      addr_q, addr_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      pop;
  logic                      fifo_empty;
  logic                      spike_drop;
  logic [AER_WIDTH-1:0]      fifo_head;

  sync_fifo #(
    .WIDTH (AER_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .srst      (RST),
    .push_i    (spike_in),
    .pop_i     (pop),
    .wr_data_i (spike_addr),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign spike_drop = spike_in && fifo_full && !pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      drop_q     <= '0;
    end else begin
      ack_meta_q <= AEROUT_ACK;
      ack_s_q    <= ack_meta_q;
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (!fifo_empty) state_d = ST_REQ_HI;
      ST_REQ_HI:      if (ack_s_q)     state_d = ST_WAIT_ACK_LO;
      ST_WAIT_ACK_LO: if (!ack_s_q)    state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // The address register only loads on a pop, so it stays put for the whole handshake.
  always_comb begin
    pop    = 1'b0;
    req_d  = req_q;
    addr_d = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          addr_d = fifo_head;
          req_d  = 1'b1;
        end
      end
      ST_REQ_HI: if (ack_s_q) req_d = 1'b0;
      default: ;
    endcase
  end

  // Window clear beats a coincident drop; the count saturates instead of wrapping.
  always_comb begin
    drop_d = drop_q;
    if (time_ref_event)
      drop_d = '0;
    else if (spike_drop && (drop_q != '1))
      drop_d = drop_q + DROP_CNT_WIDTH'(1);
  end

  assign AEROUT_ADDR = addr_q;
  assign AEROUT_REQ  = req_q;
  assign drop_cnt    = drop_q;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Self-checking bench: a queue/occupancy reference model plus a 4-phase ACK
// responder drive the encoder through latency, overflow, reset and random traffic.
module tb_aer_spike_encoder;

  localparam int AW    = 12;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int DMAX  = (1 << DW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          spike_in = 1'b0;
  logic [AW-1:0] spike_addr = '0;
  logic          time_ref_event = 1'b0;
  logic [AW-1:0] AEROUT_ADDR;
  logic          AEROUT_REQ;
  logic          AEROUT_ACK = 1'b0;
  logic          busy;
  logic          fifo_full;
  logic [DW-1:0] drop_cnt;

  always #5 CLK = ~CLK;

  aer_spike_encoder #(
    .AER_WIDTH      (AW),
    .FIFO_DEPTH     (DEPTH),
    .DROP_CNT_WIDTH (DW)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .spike_in       (spike_in),
    .spike_addr     (spike_addr),
    .time_ref_event (time_ref_event),
    .AEROUT_ADDR    (AEROUT_ADDR),
    .AEROUT_REQ     (AEROUT_REQ),
    .AEROUT_ACK     (AEROUT_ACK),
    .busy           (busy),
    .fifo_full      (fifo_full),
    .drop_cnt       (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: accepted spikes in order, observed events, occupancy, drops.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];
  int            m_count = 0;
  int            m_drop  = 0;
  logic          req_prev = 1'b0;
  logic [AW-1:0] last_addr = '0;
  bit            last_pop = 1'b0;
  int            n_req = 0;

  bit rsp_en    = 1'b0;
  int rsp_fixed = 0;
  int rsp_wait  = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            ack_dly;
    logic          req_c1;
    logic          req_c2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_delay();
    return (rsp_fixed > 0) ? rsp_fixed : int'($urandom_range(1, 10));
  endfunction

  task automatic step(input logic sp, input logic [AW-1:0] ad, input logic tr);
    bit pop;
    bit accept;
    spike_in       = sp;
    spike_addr     = ad;
    time_ref_event = tr;
    @(posedge CLK);
    #1;
    spike_in       = 1'b0;
    time_ref_event = 1'b0;
    if (RST) begin
      m_count   = 0;
      m_drop    = 0;
      exp_q     = got_q;
      last_pop  = 1'b0;
      req_prev  = 1'b0;
      last_addr = '0;
      chk("rst_req", AEROUT_REQ, 0);
      chk("rst_addr", AEROUT_ADDR, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_drop", drop_cnt, 0);
    end else begin
      pop      = AEROUT_REQ && !req_prev;
      last_pop = pop;
      if (pop) begin
        got_q.push_back(AEROUT_ADDR);
        n_req++;
        last_addr = AEROUT_ADDR;
      end else begin
        chk("addr_hold", AEROUT_ADDR, last_addr);
      end
      if (sp) begin
        accept = (m_count < DEPTH) || pop;
        if (accept) begin
          exp_q.push_back(ad);
          m_count++;
        end else if (m_drop < DMAX) begin
          m_drop++;
        end
      end
      if (pop) m_count--;
      if (tr) m_drop = 0;
      chk("fifo_full", fifo_full, (m_count == DEPTH));
      chk("drop_cnt", drop_cnt, m_drop);
      req_prev = AEROUT_REQ;
    end
    // ACK follows REQ after a delay: one 4-phase receiver.
    if (rsp_en && (AEROUT_ACK != AEROUT_REQ)) begin
      if (rsp_wait <= 0) begin
        AEROUT_ACK = AEROUT_REQ;
        rsp_wait   = next_delay();
      end else begin
        rsp_wait--;
      end
    end
  endtask

  task automatic do_reset();
    RST        = 1'b1;
    AEROUT_ACK = 1'b0;
    rsp_en     = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    RST = 1'b0;
    got_q.delete();
    exp_q.delete();
    n_req = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((busy || AEROUT_ACK || AEROUT_REQ) && (n < budget)) begin
      step(1'b0, '0, 1'b0);
      n++;
    end
    chk({tag, "_drain_timeout"}, (n < budget), 1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; (i < exp_q.size()) && (i < got_q.size()); i++)
      chk({tag, "_order"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   n_acc;
    vecs[0] = '{addr: 12'h05A, ack_dly: 3, req_c1: 1'b0, req_c2: 1'b1};
    vecs[1] = '{addr: 12'hFFF, ack_dly: 1, req_c1: 1'b0, req_c2: 1'b1};
    vecs[2] = '{addr: 12'h000, ack_dly: 7, req_c1: 1'b0, req_c2: 1'b1};
    vecs[3] = '{addr: 12'hA5C, ack_dly: 10, req_c1: 1'b0, req_c2: 1'b1};

    do_reset();

    // Single spikes into an idle encoder: REQ rises in the second cycle after presentation.
    foreach (vecs[v]) begin
      n_req     = 0;
      rsp_en    = 1'b1;
      rsp_fixed = vecs[v].ack_dly;
      rsp_wait  = vecs[v].ack_dly;
      step(1'b1, vecs[v].addr, 1'b0);
      chk("single_req_c1", AEROUT_REQ, vecs[v].req_c1);
      chk("single_busy", busy, 1);
      step(1'b0, '0, 1'b0);
      chk("single_req_c2", AEROUT_REQ, vecs[v].req_c2);
      chk("single_addr", AEROUT_ADDR, vecs[v].addr);
      drain("single", 100);
      chk("single_handshakes", n_req, 1);
      chk("single_busy_after", busy, 0);
      check_stream("single");
    end

    // Burst with ACK held low: one event in flight plus 16 buffered, then 2 drops.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, AW'(i), 1'b0);
    chk("burst_full", fifo_full, 1);
    chk("burst_req", AEROUT_REQ, 1);
    step(1'b1, AW'(17), 1'b0);
    step(1'b1, AW'(18), 1'b0);
    chk("burst_drop2", drop_cnt, 2);

    // Push lands exactly on the edge that pops a full buffer.
    AEROUT_ACK = 1'b1;
    for (int i = 0; (i < 12) && AEROUT_REQ; i++) step(1'b0, '0, 1'b0);
    chk("pp_req_low", AEROUT_REQ, 0);
    AEROUT_ACK = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 12'h100, 1'b0);
    chk("pp_pop_same_edge", last_pop, 1);
    chk("pp_addr", AEROUT_ADDR, 1);
    chk("pp_full", fifo_full, 1);
    chk("pp_drop_unchanged", drop_cnt, 2);

    // Saturate the drop counter, then clear it on a coincident drop.
    for (int i = 0; i < DMAX - 2; i++) step(1'b1, AW'($urandom_range(0, 4095)), 1'b0);
    chk("sat_at_max", drop_cnt, DMAX);
    step(1'b1, 12'h3AB, 1'b0);
    chk("sat_no_wrap", drop_cnt, DMAX);
    step(1'b1, 12'h3AC, 1'b1);
    chk("clear_wins", drop_cnt, 0);

    rsp_en    = 1'b1;
    rsp_fixed = 0;
    rsp_wait  = 1;
    drain("burst", 3000);
    n_acc = got_q.size();
    chk("burst_emitted", n_acc, 18);
    for (int i = 0; (i < 17) && (i < n_acc); i++) chk("burst_seq", got_q[i], i);
    if (n_acc > 17) chk("burst_tail", got_q[17], 12'h100);
    check_stream("burst");

    // Reset in the middle of a handshake with five entries queued.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, AW'(12'h200 + i), 1'b0);
    chk("mid_req_hi", AEROUT_REQ, 1);
    chk("mid_busy", busy, 1);
    RST = 1'b1;
    step(1'b1, 12'h2FF, 1'b0);
    RST   = 1'b0;
    n_req = 0;
    AEROUT_ACK = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    AEROUT_ACK = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);
    chk("mid_no_replay", n_req, 0);
    chk("mid_busy_after", busy, 0);
    chk("mid_req_after", AEROUT_REQ, 0);
    check_stream("mid");

    // Random traffic with random ACK latency, enough spikes to wrap pointers twice.
    do_reset();
    rsp_en    = 1'b1;
    rsp_fixed = 0;
    rsp_wait  = 1;
    for (int i = 0; i < 40; i++) begin
      int gap;
      step(1'b1, AW'($urandom_range(0, 4095)), 1'b0);
      gap = int'($urandom_range(12, 30));
      for (int g = 0; g < gap; g++) step(1'b0, '0, 1'b0);
    end
    drain("rand", 3000);
    chk("rand_drop", drop_cnt, m_drop);
    chk("rand_total", got_q.size() + m_drop, 40);
    check_stream("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
